// File: rtl/xm_shift_pkg.sv
// rtl/xm_shift_pkg.sv - shared types for the X-Makina SRA/RRC shift sequencer
package xm_shift_pkg;

  typedef enum logic [1:0] {
    OP_SRA  = 2'd0,
    OP_RRC  = 2'd1,
    OP_PASS = 2'd2
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_C = 2'd0,
    ST_Z = 2'd1,
    ST_N = 2'd2,
    ST_V = 2'd3
  } status_idx_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } seq_state_e;

  // Encodings 2 and 3 both mean pass, so only SRA/RRC do any stepping.
  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == OP_SRA) || (op == OP_RRC);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit SRA/RRC step on word or low byte
module shift_step
  import xm_shift_pkg::*;
#(
  parameter int WORD = 16
) (
  input  shift_op_e        op,
  input  logic             byte_mode,
  input  logic [WORD-1:0]  w,
  input  logic             c_in,
  output logic [WORD-1:0]  w_next,
  output logic             c_out
);

  // Upper byte is carried through untouched in byte mode.
  always_comb begin
    w_next = w;
    c_out  = w[0];
    case (op)
      OP_SRA: begin
        if (byte_mode) w_next[7:0] = {w[7], w[7:1]};
        else           w_next      = {w[WORD-1], w[WORD-1:1]};
      end
      OP_RRC: begin
        if (byte_mode) w_next[7:0] = {c_in, w[7:1]};
        else           w_next      = {c_in, w[WORD-1:1]};
      end
      default: begin
        w_next = w;
        c_out  = c_in;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - one-bit-per-clock sequencer for multi-count SRA/RRC
module shift_sequencer
  import xm_shift_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ready,
  output logic                      busy,
  input  logic [1:0]                operation,
  input  logic                      byte_mode,
  input  logic [$clog2(WORD)-1:0]   shift,
  input  logic [WORD-1:0]           in,
  input  logic [3:0]                status_old,
  output logic [3:0]                status_new,
  output logic [WORD-1:0]           out,
  output logic                      done
);

  localparam int SW = $clog2(WORD);

  seq_state_e      state;
  logic [SW-1:0]   remaining;
  logic [WORD-1:0] w_q;
  logic            c_q;
  logic            v_q;
  logic            byte_q;
  shift_op_e       op_q;

  logic [WORD-1:0] w_next;
  logic            c_out;
  logic [3:0]      final_status;

  shift_step #(.WORD(WORD)) u_step (
    .op        (op_q),
    .byte_mode (byte_q),
    .w         (w_q),
    .c_in      (c_q),
    .w_next    (w_next),
    .c_out     (c_out)
  );

  // Status as it will read after the step that finishes the count.
  always_comb begin
    final_status       = '0;
    final_status[ST_C] = c_out;
    final_status[ST_Z] = byte_q ? (w_next[7:0] == 8'h00) : (w_next == '0);
    final_status[ST_N] = byte_q ? w_next[7] : w_next[WORD-1];
    final_status[ST_V] = v_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      w_q        <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      byte_q     <= 1'b0;
      op_q       <= OP_SRA;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      out        <= '0;
      status_new <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            w_q       <= in;
            c_q       <= status_old[ST_C];
            v_q       <= status_old[ST_V];
            byte_q    <= byte_mode;
            remaining <= shift;
            ready     <= 1'b0;
            busy      <= 1'b1;
            // Zero count or pass resolves on the accept edge itself.
            if ((shift == '0) || !is_shift_op(operation)) begin
              op_q       <= OP_PASS;
              out        <= in;
              status_new <= status_old;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              op_q  <= shift_op_e'(operation);
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          w_q       <= w_next;
          c_q       <= c_out;
          remaining <= remaining - SW'(1);
          if (remaining == SW'(1)) begin
            out        <= w_next;
            status_new <= final_status;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready, busy, done;
  logic [1:0]  operation = 2'd0;
  logic        byte_mode = 1'b0;
  logic [3:0]  shift = 4'd0;
  logic [15:0] din = 16'h0;
  logic [3:0]  status_old = 4'h0;
  logic [3:0]  status_new;
  logic [15:0] dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WORD(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .busy       (busy),
    .operation  (operation),
    .byte_mode  (byte_mode),
    .shift      (shift),
    .in         (din),
    .status_old (status_old),
    .status_new (status_new),
    .out        (dout),
    .done       (done)
  );

  typedef struct {
    logic [1:0]  op;
    logic        bm;
    logic [3:0]  sh;
    logic [15:0] din;
    logic [3:0]  st;
    logic [15:0] eo;
    logic [3:0]  es;
    int          el;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic shift of the sign-extended operand, or rotation of the {C,operand} ring.
  task automatic model(input logic [1:0] op, input logic bm, input logic [3:0] sh,
                       input logic [15:0] a, input logic [3:0] st,
                       output logic [15:0] o, output logic [3:0] s, output int lat);
    int sx, res, k, len;
    logic [63:0] ring, rot, mask;
    logic c;
    if (op > 2'd1 || sh == 4'd0) begin
      o = a; s = st; lat = 0;
    end else begin
      lat = int'(sh);
      if (op == 2'd0) begin
        sx  = bm ? int'($signed(a[7:0])) : int'($signed(a));
        res = sx >>> sh;
        c   = ((sx >>> (sh - 1)) & 1) != 0;
      end else begin
        len  = bm ? 9 : 17;
        ring = bm ? {55'd0, st[0], a[7:0]} : {47'd0, st[0], a};
        mask = (64'd1 << len) - 64'd1;
        k    = int'(sh) % len;
        rot  = ((ring >> k) | (ring << (len - k))) & mask;
        res  = int'(rot[31:0] & ((32'd1 << (len - 1)) - 32'd1));
        c    = rot[len-1];
      end
      o = bm ? {a[15:8], res[7:0]} : res[15:0];
      s[0] = c;
      s[1] = bm ? (o[7:0] == 8'h00) : (o == 16'h0);
      s[2] = bm ? o[7] : o[15];
      s[3] = st[3];
    end
  endtask

  // Issues one request, scrambles inputs after acceptance, waits (bounded) for done.
  task automatic run_req(input logic [1:0] op, input logic bm, input logic [3:0] sh,
                         input logic [15:0] a, input logic [3:0] st,
                         output logic [15:0] o, output logic [3:0] s, output int lat,
                         output logic seen, output logic busy_at_done,
                         output logic done_after, output logic ready_after);
    @(negedge clk);
    operation = op; byte_mode = bm; shift = sh; din = a; status_old = st; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operation = 2'($urandom); byte_mode = 1'($urandom);
    shift = 4'($urandom); din = 16'($urandom); status_old = 4'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    seen = done;
    o = dout; s = status_new; busy_at_done = busy;
    @(posedge clk); #1;
    done_after = done; ready_after = ready;
  endtask

  initial begin
    logic [15:0] o, eo;
    logic [3:0]  s, es;
    int lat, el;
    logic seen, bad, rd, da;
    logic done_seen;

    vecs[0] = '{2'd0, 1'b0, 4'd1,  16'h8001, 4'b0000, 16'hC000, 4'b0101, 1};
    vecs[1] = '{2'd1, 1'b0, 4'd2,  16'h0001, 4'b0001, 16'hC000, 4'b0100, 2};
    vecs[2] = '{2'd0, 1'b1, 4'd4,  16'h12F0, 4'b0000, 16'h12FF, 4'b0100, 4};
    vecs[3] = '{2'd0, 1'b0, 4'd3,  16'h0004, 4'b1000, 16'h0000, 4'b1011, 3};
    vecs[4] = '{2'd0, 1'b0, 4'd0,  16'h0000, 4'b1011, 16'h0000, 4'b1011, 0};
    vecs[5] = '{2'd2, 1'b0, 4'd5,  16'h0000, 4'b1011, 16'h0000, 4'b1011, 0};
    vecs[6] = '{2'd3, 1'b1, 4'd7,  16'hABCD, 4'b0110, 16'hABCD, 4'b0110, 0};
    vecs[7] = '{2'd1, 1'b1, 4'd9,  16'h3401, 4'b0000, 16'h3401, 4'b0000, 9};
    vecs[8] = '{2'd0, 1'b0, 4'd15, 16'h8000, 4'b0000, 16'hFFFF, 4'b0100, 15};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", dout, 0);
    check("rst_status", status_new, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].op, vecs[i].bm, vecs[i].sh, vecs[i].din, vecs[i].st,
              o, s, lat, seen, bad, da, rd);
      check($sformatf("vec%0d_done", i), seen, 1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].el);
      check($sformatf("vec%0d_out", i), o, vecs[i].eo);
      check($sformatf("vec%0d_status", i), s, vecs[i].es);
      check($sformatf("vec%0d_busy_at_done", i), bad, 1);
      check($sformatf("vec%0d_done_pulse", i), da, 0);
      check($sformatf("vec%0d_ready_after", i), rd, 1);
    end

    // Long request, ignored restart at E3, asynchronous abort before E7.
    @(negedge clk);
    operation = 2'd0; byte_mode = 1'b0; shift = 4'd15; din = 16'h1234; status_old = 4'b0000;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    operation = 2'd2; shift = 4'd0; din = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_ignored_done", done, 0);
    check("restart_ignored_busy", busy, 1);
    check("restart_ignored_ready", ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out", dout, 0);
    check("abort_status", status_new, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_idle_ready", ready, 1);

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  rop;
      logic        rbm;
      logic [3:0]  rsh, rst_old;
      logic [15:0] rin;
      rop = 2'($urandom_range(0, 3));
      rbm = 1'($urandom);
      rsh = 4'($urandom);
      rin = 16'($urandom);
      rst_old = 4'($urandom);
      model(rop, rbm, rsh, rin, rst_old, eo, es, el);
      run_req(rop, rbm, rsh, rin, rst_old, o, s, lat, seen, bad, da, rd);
      check($sformatf("rnd%0d_latency op=%0d bm=%0d sh=%0d in=%h", i, rop, rbm, rsh, rin), lat, el);
      check($sformatf("rnd%0d_out op=%0d bm=%0d sh=%0d in=%h", i, rop, rbm, rsh, rin), o, eo);
      check($sformatf("rnd%0d_status op=%0d bm=%0d sh=%0d st=%b", i, rop, rbm, rsh, rst_old), s, es);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that sequences a single-bit shift step to execute X-Makina SRA and RRC instructions of arbitrary count, one bit per clock. Sits between the control unit and the register file write-back path in the multi-cycle core. It accepts one request through a start/ready handshake, iterates the step datapath, and returns a registered result and updated CZNV status with a one-cycle done pulse.

## Interface
Parameters:
- WORD, 16, datapath width in bits; byte mode always operates on bits [7:0].

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only on an edge where ready=1.
- ready  out  1  high in IDLE; low otherwise.
- busy  out  1  high in SHIFT and DONE.
- operation  in  2  0=SRA, 1=RRC, 2/3=pass.
- byte_mode  in  1  1 = operate on the low byte; upper byte is preserved.
- shift  in  $clog2(WORD)  shift count, 0..WORD-1.
- in  in  WORD  operand.
- status_old  in  4  {V,N,Z,C}: bit0=C, bit1=Z, bit2=N, bit3=V.
- status_new  out  4  resolved status, same bit order.
- out  out  WORD  result.
- done  out  1  one-cycle pulse; out and status_new are valid.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE & start: latch operation, byte_mode, in, status_old, and remaining=shift into working registers.
  - Go to DONE if shift==0 or operation is pass.
  - Otherwise go to SHIFT.
- SHIFT, each edge: apply one step to the working value and C, then decrement remaining. When remaining==1 before the decrement, go to DONE.
- DONE: done=1; next edge goes to IDLE. There is no back-to-back acceptance.
- SRA step:
  - Word mode: new = {w[WORD-1], w[WORD-1:1]}.
  - Byte mode: the same on w[7:0] with sign bit 7.
  - C = bit shifted out (w[0]).
- RRC step:
  - Word mode: new = {C, w[WORD-1:1]}.
  - Byte mode: new[7:0] = {C, w[7:1]}.
  - C = w[0].
- Final status for SRA/RRC with count>0:
  - C = last bit shifted out.
  - Z = result (low byte in byte mode) is zero.
  - N = result MSB (bit 7 in byte mode).
  - V = status_old V, passed through.
- Count 0 or pass: out=in, status_new=status_old unchanged.
- Byte mode: out[WORD-1:8] = in[WORD-1:8].
  - Counts ≥8 iterate normally (SRA saturates to all sign bits; RRC keeps rotating the 9-bit ring).
- start while busy is ignored. The latched request is unaffected by input changes after acceptance.

## Timing
- Accept edge E0. done is high in the cycle after edge E_n, where n = effective count (0 for pass).
- Latency in clock edges = n+1 from accept to return to IDLE; ready returns in the cycle after DONE.
- out and status_new are registered:
  - They update on the DONE-entry edge only.
  - They hold until the next DONE entry; intermediate working values are never visible.
- Reset values: state=IDLE, ready=1, busy=0, done=0, out=0, status_new=0, remaining=0.
- Reset mid-operation aborts immediately and asynchronously; no done pulse is produced for the aborted request.

## Structure
- Package xm_shift_pkg holds:
  - the enum of shift operations (SRA=0, RRC=1, PASS=2);
  - the status bit index enum (C=0, Z=1, N=2, V=3);
  - the state enum.
- Sub-module shift_step: a combinational single-bit step with inputs op, byte_mode, w, c_in and outputs w_next, c_out. The sequencer holds all registers and the FSM.

## Test plan
- SRA word, in=0x8001, shift=1, status_old=4'b0000 -> done after E1, out=0xC000, status_new=4'b0101.
- RRC word, in=0x0001, status_old=4'b0001, shift=2 -> done after E2, out=0xC000, status_new=4'b0100.
- SRA byte, in=0x12F0, shift=4 -> done after E4, out=0x12FF, status_new=4'b0100 (C=0, N=1).
- SRA word, in=0x0004, shift=3, status_old=4'b1000 -> out=0x0000, status_new=4'b1011 (V passed through, Z=1, C=1).
- shift=0 or operation=2, in=0x0000, status_old=4'b1011 -> done after E0, out=0x0000, status_new=4'b1011.
- shift=15 request, pulse start again at E3, then assert rst at E7 -> second start ignored; after rst: ready=1, busy=0, out=0, status_new=0, no done pulse.
